// File: rtl/rob_complete_arb.sv
// rtl/rob_complete_arb.sv - per-requester completion FIFOs feeding a round-robin ROB wakeup arbiter
package core_pkg;
  localparam int ROB_ENTRIES = 32;
endpackage

module rob_complete_arb #(
  parameter int NUM_REQ    = 3,
  parameter int FIFO_DEPTH = 2,
  parameter int ROB_SIZE   = core_pkg::ROB_ENTRIES,
  parameter int IDX_BITS   = $clog2(ROB_SIZE)
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0][IDX_BITS-1:0] req_idx,
  input  logic [NUM_REQ-1:0]               req_exc,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic                             flush_en,
  output logic                             mark_ready_en,
  output logic [IDX_BITS-1:0]              mark_ready_idx,
  output logic                             mark_ready_val,
  output logic                             mark_exception,
  output logic [NUM_REQ-1:0]               grant_oh,
  output logic                             busy
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int RR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int ENT_W = IDX_BITS + 1;

  logic [ENT_W-1:0] mem    [NUM_REQ][FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr [NUM_REQ];
  logic [PTR_W-1:0] rd_ptr [NUM_REQ];
  logic [CNT_W-1:0] count  [NUM_REQ];
  logic [RR_W-1:0]  rr_ptr;

  logic [NUM_REQ-1:0] push;
  logic [NUM_REQ-1:0] pop;
  logic [NUM_REQ-1:0] nonempty;
  logic               gnt_found;
  logic [RR_W-1:0]    gnt_sel;
  logic [ENT_W-1:0]   head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (int'(p) == FIFO_DEPTH - 1) return '0;
    return p + PTR_W'(1);
  endfunction

  // Ready looks only at the registered count, never at this cycle's pop.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      nonempty[i]  = (count[i] != '0);
      req_ready[i] = (int'(count[i]) < FIFO_DEPTH) && !flush_en;
      push[i]      = req_valid[i] && req_ready[i];
    end
  end

  assign busy = |nonempty;

  always_comb begin
    int            cand;
    logic [RR_W-1:0] cand_w;
    gnt_found = 1'b0;
    gnt_sel   = '0;
    cand      = 0;
    cand_w    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_w = RR_W'(cand);
      if (!gnt_found && nonempty[cand_w]) begin
        gnt_found = 1'b1;
        gnt_sel   = cand_w;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      pop[i] = gnt_found && (gnt_sel == RR_W'(i));
    end
  end

  assign head           = mem[gnt_sel][rd_ptr[gnt_sel]];
  assign mark_ready_val = mark_ready_en;

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= {req_idx[i], req_exc[i]};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
      rr_ptr         <= '0;
      mark_ready_en  <= 1'b0;
      mark_ready_idx <= '0;
      mark_exception <= 1'b0;
      grant_oh       <= '0;
    end else if (flush_en) begin
      // Flush outranks both enqueue and grant; the last index is left as is.
      for (int i = 0; i < NUM_REQ; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
      rr_ptr         <= '0;
      mark_ready_en  <= 1'b0;
      mark_exception <= 1'b0;
      grant_oh       <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (push[i]) wr_ptr[i] <= ptr_inc(wr_ptr[i]);
        if (pop[i])  rd_ptr[i] <= ptr_inc(rd_ptr[i]);
        count[i] <= count[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
      end
      if (gnt_found) begin
        rr_ptr         <= (int'(gnt_sel) == NUM_REQ - 1) ? '0 : gnt_sel + RR_W'(1);
        mark_ready_en  <= 1'b1;
        mark_ready_idx <= head[ENT_W-1:1];
        mark_exception <= head[0];
        grant_oh       <= NUM_REQ'(1) << gnt_sel;
      end else begin
        mark_ready_en  <= 1'b0;
        mark_exception <= 1'b0;
        grant_oh       <= '0;
      end
    end
  end
endmodule

// File: tb/tb_rob_complete_arb.sv
// tb/tb_rob_complete_arb.sv - directed and random checks of rob_complete_arb against a queue model
module tb_rob_complete_arb;
  localparam int N  = 3;
  localparam int IW = 5;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [N-1:0]          req_valid = '0;
  logic [N-1:0][IW-1:0]  req_idx = '0;
  logic [N-1:0]          req_exc = '0;
  logic [N-1:0]          req_ready;
  logic              flush_en = 1'b0;
  logic              mark_ready_en;
  logic [IW-1:0]     mark_ready_idx;
  logic              mark_ready_val;
  logic              mark_exception;
  logic [N-1:0]      grant_oh;
  logic              busy;

  int errors = 0;
  int checks = 0;

  // Model: one queue of idx*2+exc per requester, plus the expected registered outputs.
  int q [N][$];
  int rr = 0;
  int m_en = 0, m_idx = 0, m_exc = 0, m_goh = 0;
  int got0 [$];
  int seq [3] = '{7, 8, 9};

  rob_complete_arb dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_idx(req_idx),
    .req_exc(req_exc), .req_ready(req_ready), .flush_en(flush_en),
    .mark_ready_en(mark_ready_en), .mark_ready_idx(mark_ready_idx),
    .mark_ready_val(mark_ready_val), .mark_exception(mark_exception),
    .grant_oh(grant_oh), .busy(busy)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int busy_exp();
    for (int i = 0; i < N; i++) if (q[i].size() > 0) return 1;
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) q[i].delete();
    rr = 0; m_en = 0; m_idx = 0; m_exc = 0; m_goh = 0;
  endtask

  task automatic model_edge();
    int g, c, e;
    logic [N-1:0] acc;
    if (flush_en) begin
      for (int i = 0; i < N; i++) q[i].delete();
      rr = 0; m_en = 0; m_exc = 0; m_goh = 0;
      return;
    end
    for (int i = 0; i < N; i++) acc[i] = req_valid[i] && (q[i].size() < 2);
    g = -1;
    for (int k = 0; k < N; k++) begin
      c = (rr + k) % N;
      if (g < 0 && q[c].size() > 0) g = c;
    end
    if (g >= 0) begin
      e = q[g].pop_front();
      m_en = 1; m_idx = e / 2; m_exc = e % 2; m_goh = 1 << g; rr = (g + 1) % N;
    end else begin
      m_en = 0; m_exc = 0; m_goh = 0;
    end
    for (int i = 0; i < N; i++) if (acc[i]) q[i].push_back(int'(req_idx[i]) * 2 + int'(req_exc[i]));
  endtask

  task automatic step();
    logic [N-1:0] er;
    #1;
    for (int i = 0; i < N; i++) er[i] = (q[i].size() < 2) && !flush_en;
    chk("req_ready", req_ready, er);
    chk("busy_pre", busy, busy_exp());
    model_edge();
    @(posedge clk); #1;
    chk("mark_en", mark_ready_en, m_en);
    chk("mark_val", mark_ready_val, m_en);
    chk("mark_idx", mark_ready_idx, m_idx);
    chk("mark_exc", mark_exception, m_exc);
    chk("grant_oh", grant_oh, m_goh);
    chk("busy_post", busy, busy_exp());
    if (mark_ready_en && grant_oh == 3'b001) got0.push_back(int'(mark_ready_idx));
  endtask

  task automatic idle(input int n);
    req_valid = '0; flush_en = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    req_valid = '0; flush_en = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_en", mark_ready_en, 0);
    chk("rst_idx", mark_ready_idx, 0);
    chk("rst_goh", grant_oh, 0);
    chk("rst_ready", req_ready, 3'b111);
    model_reset();
    @(posedge clk); #1;
    chk("rst_ready_edge", req_ready, 3'b111);
    reset_n = 1'b1;
  endtask

  initial begin
    #2;
    chk("init_en", mark_ready_en, 0);
    chk("init_val", mark_ready_val, 0);
    chk("init_goh", grant_oh, 0);
    chk("init_busy", busy, 0);
    chk("init_ready", req_ready, 3'b111);
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;

    // single completion: visible exactly two edges after acceptance
    req_valid = 3'b010; req_idx[1] = 5; req_exc = '0;
    step();
    chk("single_t1", mark_ready_en, 0);
    idle(1);
    chk("single_en", mark_ready_en, 1);
    chk("single_idx", mark_ready_idx, 5);
    chk("single_goh", grant_oh, 3'b010);
    idle(1);
    chk("single_off", mark_ready_en, 0);

    // round robin from rr_ptr=0 (flush forces it)
    flush_en = 1'b1; step(); flush_en = 1'b0;
    req_valid = 3'b111; req_idx[0] = 1; req_idx[1] = 2; req_idx[2] = 3;
    step();
    idle(1); chk("rr_g0", grant_oh, 3'b001); chk("rr_i0", mark_ready_idx, 1);
    idle(1); chk("rr_g1", grant_oh, 3'b010); chk("rr_i1", mark_ready_idx, 2);
    idle(1); chk("rr_g2", grant_oh, 3'b100); chk("rr_i2", mark_ready_idx, 3);
    chk("rr_busy", busy, 0);
    idle(1);

    // exception
    req_valid = 3'b100; req_idx[2] = 12; req_exc = 3'b100;
    step(); req_exc = '0;
    idle(1);
    chk("exc_en", mark_ready_en, 1);
    chk("exc_idx", mark_ready_idx, 12);
    chk("exc_flag", mark_exception, 1);
    chk("exc_goh", grant_oh, 3'b100);
    idle(1);

    // backpressure: requester 0 holds each offer until accepted
    begin
      int p;
      logic acc0;
      p = 0; got0.delete();
      for (int c = 0; c < 20; c++) begin
        req_valid[0] = (p < 3);
        req_idx[0] = IW'(seq[p < 3 ? p : 2]);
        req_valid[2:1] = 2'b11;
        req_idx[1] = IW'($urandom); req_idx[2] = IW'($urandom);
        req_exc = N'($urandom);
        acc0 = req_valid[0] && (q[0].size() < 2);
        step();
        if (acc0) p++;
      end
      idle(8);
      chk("bp_count", got0.size(), 3);
      for (int i = 0; i < 3; i++) chk("bp_order", (i < got0.size()) ? got0[i] : -1, seq[i]);
    end

    // asynchronous reset with two entries buffered
    req_valid = 3'b001; req_idx[0] = 10; step();
    req_valid = 3'b011; req_idx[0] = 11; req_idx[1] = 20; step();
    chk("pre_rst_busy", busy, 1);
    do_reset();
    idle(4);

    // flush with two buffered entries and a new offer
    req_valid = 3'b011; req_idx[0] = 4; req_idx[1] = 6; step();
    flush_en = 1'b1; req_valid = 3'b001; req_idx[0] = 9; step();
    chk("flush_en0", mark_ready_en, 0);
    chk("flush_busy", busy, 0);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      chk("flush_quiet", mark_ready_en, 0);
    end
    req_valid = 3'b110; req_idx[1] = 13; req_idx[2] = 14; step();
    idle(1); chk("flush_g1", grant_oh, 3'b010); chk("flush_i1", mark_ready_idx, 13);
    idle(1); chk("flush_g2", grant_oh, 3'b100); chk("flush_i2", mark_ready_idx, 14);

    // random traffic with occasional flush and one mid-run reset
    for (int c = 0; c < 300; c++) begin
      if (c == 150) do_reset();
      req_valid = N'($urandom);
      for (int i = 0; i < N; i++) req_idx[i] = IW'($urandom);
      req_exc = N'($urandom);
      flush_en = ($urandom_range(0, 39) == 0);
      step();
    end
    idle(8);
    chk("final_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rob_complete_arb.md
ROB_COMPLETE_ARB -- requirements
Module: rob_complete_arb

Interface
REQ-001 Parameters SHALL be, one per line:
- NUM_REQ, 3, number of execution-unit completion requesters.
- FIFO_DEPTH, 2, completion buffer entries per requester.
- ROB_SIZE, core_pkg::ROB_ENTRIES, ROB entry count.
- IDX_BITS, $clog2(ROB_SIZE), ROB index width.
REQ-002 The block SHALL use one clock; reset SHALL be asynchronous and active-low.
REQ-003 Ports SHALL be, one per line:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  [NUM_REQ]  completion offered by requester i.
- req_idx  in  [NUM_REQ] x IDX_BITS  ROB index of the completing op.
- req_exc  in  [NUM_REQ]  exception flag of the completing op.
- req_ready  out  [NUM_REQ]  requester i completion accepted this cycle.
- flush_en  in  1  synchronous pipeline flush.
- mark_ready_en  out  1  ROB wakeup strobe.
- mark_ready_idx  out  IDX_BITS  ROB index to mark complete.
- mark_ready_val  out  1  ready flag; equals mark_ready_en.
- mark_exception  out  1  exception flag of the granted completion.
- grant_oh  out  [NUM_REQ]  one-hot source of the current strobe.
- busy  out  1  any completion buffer non-empty.

Function
REQ-004 Each requester SHALL own a FIFO_DEPTH-entry in-order FIFO of {idx, exc}, with a count of 0..FIFO_DEPTH.
REQ-005 req_ready[i] SHALL be combinational: (count[i] < FIFO_DEPTH) && !flush_en. It SHALL NOT depend on a same-cycle dequeue.
REQ-006 A completion SHALL be enqueued at the rising edge when req_valid[i] && req_ready[i]. Otherwise req_idx and req_exc SHALL be ignored.
REQ-007 Every cycle, the arbiter SHALL select at most one non-empty FIFO, searching round-robin from rr_ptr upward and wrapping at NUM_REQ.
REQ-008 On a grant to g, rr_ptr SHALL become (g+1) mod NUM_REQ and FIFO g SHALL pop its head.
- With no grant, rr_ptr SHALL hold.
REQ-009 Outputs mark_ready_en, mark_ready_idx, mark_ready_val, mark_exception and grant_oh SHALL be registered from the selection.
- With no grant, mark_ready_en, mark_ready_val, mark_exception and grant_oh SHALL be 0.
- With no grant, mark_ready_idx SHALL hold its previous value.
REQ-010 Latency: a completion accepted in cycle t SHALL produce mark_ready_en=1 no earlier than cycle t+2 and exactly at t+2 if its FIFO is granted at the first opportunity.
REQ-011 Simultaneous enqueue and pop on one FIFO SHALL leave the count unchanged and preserve order.
- Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-012 Completions from one requester SHALL be emitted in acceptance order. No completion SHALL be dropped or duplicated except by flush.
REQ-013 At most one mark_ready_en pulse SHALL occur per cycle. Each accepted completion SHALL produce exactly one single-cycle pulse.
REQ-014 A requester SHALL wait at most NUM_REQ-1 grants between its FIFO becoming non-empty and its grant.
REQ-015 flush_en=1 at an edge SHALL clear all counts and pointers and set rr_ptr=0.
- At the same edge, mark_ready_en, mark_exception and grant_oh SHALL be set to 0.
- Inputs in the flush cycle SHALL be discarded.
- Flush SHALL take priority over enqueue and grant.
REQ-016 busy SHALL be combinational OR of (count[i] != 0).

Reset
REQ-017 reset_n=0 SHALL immediately, without a clock edge, clear all FIFO counts and pointers and set rr_ptr=0.
- mark_ready_en, mark_ready_idx, mark_ready_val, mark_exception and grant_oh SHALL be 0; busy SHALL be 0.
REQ-018 During and after reset with flush_en=0, req_ready SHALL be all ones.
REQ-019 Reset asserted mid-operation SHALL discard all buffered completions. No pulse for them SHALL occur after release.

Verification
REQ-020 Reset: reset_n=0 with 2 entries buffered -> busy=0, mark_ready_en=0, req_ready=3'b111 without any clock edge.
REQ-021 Single completion: req_valid[1]=1, idx=5, exc=0 in cycle t -> in cycle t+2 only: mark_ready_en=1, mark_ready_idx=5, mark_ready_val=1, mark_exception=0, grant_oh=3'b010. The strobe SHALL then deassert.
REQ-022 Round-robin: all three requesters offer idx 1,2,3 in cycle t with rr_ptr=0 -> grants 3'b001, 3'b010, 3'b100 in cycles t+2, t+3, t+4; busy=0 in cycle t+4.
REQ-023 Backpressure: requesters 1 and 2 offer every cycle while requester 0 offers idx 7,8,9 back-to-back -> req_ready[0]=0 whenever count[0]=2, idx 9 is held until accepted, and requester 0 emits exactly 7,8,9 in order.
REQ-024 Exception: req_valid[2]=1, idx=12, exc=1 -> one pulse with mark_ready_idx=12, mark_exception=1, grant_oh=3'b100.
REQ-025 Flush: 2 entries buffered and flush_en=1 for one cycle with req_valid[0]=1 -> next cycle mark_ready_en=0 and busy=0; none of the three completions is ever emitted; the next accepted completion is granted with rr_ptr starting from 0.
